// File: rtl/robertson_sequencer.sv
// ----------------------------------------------------------------------------
// robertson_sequencer
//
// Sequential signed (two's-complement) multiplier that uses Robertson's
// add/shift algorithm. Each iteration takes two cycles:
//   ADD   - form the width+1-bit partial sum S from A and M.
//   SHIFT - arithmetic right shift of {S, Q} by one bit.
// On the final iteration the multiplicand is subtracted rather than added.
// This corrects for the negative weight of the multiplier's sign bit.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         operation request, sampled only while idle
//   multiplicand  signed operand M, captured on an accepted start
//   multiplier    signed operand Q, captured on an accepted start
//   busy          high while in ADD or SHIFT
//   done          one-cycle completion pulse
//   product       signed 2*width-bit result, held until the next completion
// ----------------------------------------------------------------------------
module robertson_sequencer #(
  parameter int width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [width-1:0]     multiplicand,
  input  logic [width-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   product
);

  localparam int cnt_w = $clog2(width);
  localparam logic [cnt_w-1:0] last_count = cnt_w'(width - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [width-1:0]     a_q, a_d;
  logic [width-1:0]     q_q, q_d;
  logic [width-1:0]     m_q, m_d;
  logic [width:0]       s_q, s_d;
  logic [cnt_w-1:0]     count_q, count_d;
  logic [2*width-1:0]   product_q, product_d;

  logic                 last_iter;
  logic [width:0]       a_ext;
  logic [width:0]       m_ext;

  // The sum is one bit wider than the operands, so it cannot overflow.
  // Because of that, the shift takes its sign from S[width] and never from A.
  assign last_iter = (count_q == last_count);
  assign a_ext     = {a_q[width-1], a_q};
  assign m_ext     = {m_q[width-1], m_q};

  assign busy    = (state_q == ADD) || (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    s_d       = s_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = multiplier;
          m_d     = multiplicand;
          count_d = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        // The last multiplier bit has negative weight, so it subtracts M.
        if (!q_q[0]) begin
          s_d = a_ext;
        end else if (last_iter) begin
          s_d = a_ext - m_ext;
        end else begin
          s_d = a_ext + m_ext;
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        a_d     = s_q[width:1];
        q_d     = {s_q[0], q_q[width-1:1]};
        count_d = count_q + cnt_w'(1);
        if (last_iter) begin
          product_d = {s_q[width:1], s_q[0], q_q[width-1:1]};
          state_d   = DONE;
        end else begin
          state_d = ADD;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      s_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      s_q       <= s_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_robertson_sequencer.sv
// ----------------------------------------------------------------------------
// tb_robertson_sequencer
//
// Scoreboard bench for robertson_sequencer at width=16 and width=8.
// Stimulus tasks push the expected product into a queue whenever they issue
// a request. Monitors pop an entry and compare it on every done pulse.
// Expected products come from a plain signed multiply.
// ----------------------------------------------------------------------------
module tb_robertson_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start8;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [7:0]  mcand8;
  logic [7:0]  mplier8;
  logic        busy;
  logic        done;
  logic        busy8;
  logic        done8;
  logic [31:0] product;
  logic [15:0] product8;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp8_q[$];
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  robertson_sequencer #(.width(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  robertson_sequencer #(.width(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start8),
    .multiplicand (mcand8),
    .multiplier   (mplier8),
    .busy         (busy8),
    .done         (done8),
    .product      (product8)
  );

  // Reference model: sign-extend both operands and multiply.
  function automatic logic [31:0] refMul16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return 32'(sa * sb);
  endfunction

  function automatic logic [15:0] refMul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb);
  endfunction

  // Operands are biased toward the corner values so they come up often.
  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Every done pulse must line up with an outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL done16_unrequested: got done=1, expected no pending request");
      end else begin
        checkOutput("product16", product, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL done8_unrequested: got done=1, expected no pending request");
      end else begin
        checkOutput("product8", {16'h0, product8}, {16'h0, exp8_q.pop_front()});
      end
    end
  end

  // Issue one single-cycle request to the 16-bit unit and follow it to done.
  // If glitch_cycle is nonzero, a stray 2*2 request is pulsed at that cycle
  // of the operation, and the unit must ignore it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int glitch_cycle);
    int n;
    int busy_cycles;
    logic [31:0] prev;
    prev = last_exp;
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    exp_q.push_back(refMul16(a, b));
    @(negedge clk);
    start       = 1'b0;
    n           = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_cycles++;
      if (n == 10) checkOutput("product_hold", product, prev);
      if (glitch_cycle > 0 && n == glitch_cycle) begin
        mcand  = 16'd2;
        mplier = 16'd2;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(n), 32'd33);
    checkOutput("busy_cycles", 32'(busy_cycles), 32'd32);
    last_exp = refMul16(a, b);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    mcand8  = a;
    mplier8 = b;
    start8  = 1'b1;
    exp8_q.push_back(refMul8(a, b));
    @(negedge clk);
    start8 = 1'b0;
    n      = 1;
    checkOutput("busy8", {31'h0, busy8}, 32'h1);
    while (done8 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency8", 32'(n), 32'd17);
  endtask

  // Hold start high across three operations. A new operand pair is presented
  // as each done appears, so it is captured in the following idle cycle.
  task automatic backToBack();
    logic [15:0] as [3];
    logic [15:0] bs [3];
    int n;
    as = '{16'd11, 16'hFFF0, 16'h0123};
    bs = '{16'd13, 16'd7,    16'hFF00};
    @(negedge clk);
    mcand  = as[0];
    mplier = bs[0];
    start  = 1'b1;
    exp_q.push_back(refMul16(as[0], bs[0]));
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 200);
      if (k == 0) checkOutput("b2b_first_latency", 32'(n), 32'd33);
      else        checkOutput("b2b_spacing", 32'(n), 32'd34);
      if (k < 2) begin
        mcand  = as[k+1];
        mplier = bs[k+1];
        exp_q.push_back(refMul16(as[k+1], bs[k+1]));
      end else begin
        start = 1'b0;
      end
    end
    last_exp = refMul16(as[2], bs[2]);
    @(negedge clk);
  endtask

  // Abandon an operation with reset partway through.
  task automatic midOpReset();
    @(negedge clk);
    mcand  = 16'h1234;
    mplier = 16'h0010;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_mid_done", {31'h0, done}, 32'h0);
    checkOutput("reset_mid_product", product, 32'h0);
    rst_n    = 1'b1;
    last_exp = '0;
    repeat (40) @(negedge clk);
    checkOutput("reset_mid_idle", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    start8  = 1'b0;
    mcand   = '0;
    mplier  = '0;
    mcand8  = '0;
    mplier8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_product", product, 32'h0);
    checkOutput("reset_product8", {16'h0, product8}, 32'h0);
    rst_n = 1'b1;

    applyStimulus(16'd3, 16'd5, 0);
    applyStimulus(16'hFFFD, 16'd5, 0);
    applyStimulus(16'd5, 16'hFFFD, 0);
    applyStimulus(16'h8000, 16'h8000, 0);
    applyStimulus(16'h7FFF, 16'h8000, 0);
    applyStimulus(16'hFFFF, 16'hFFFF, 0);
    applyStimulus(16'd9, 16'd7, 10);
    backToBack();
    midOpReset();
    applyStimulus(16'd2, 16'hFFFF, 0);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(pickOperand(), pickOperand(), 0);
    end

    applyStimulus8(8'h80, 8'h80);
    applyStimulus8(8'h7F, 8'h81);
    for (int i = 0; i < 200; i++) begin
      applyStimulus8(8'($urandom), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard16_empty", 32'(exp_q.size()), 32'h0);
    checkOutput("scoreboard8_empty", 32'(exp8_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
